// File: rtl/line_clear_engine.sv
// Post-lock line clear: snapshots the playfield, removes every full row by
// collapsing the rows above it, then publishes the grid, line count and a
// saturating score.
// Ports: clk/rst (sync, active-high); start, grid_in in; grid_out,
//        busy, done, lines_cleared, score out.
// Latency: ROWS+N+1 cycles from the start edge to done (N = full rows).
// Backpressure: none. A start that arrives while busy, or while done is high, is dropped.
module line_clear_engine #(
    parameter int ROWS      = 22,
    parameter int COLS      = 10,
    parameter int CW        = 3,
    parameter int SCORE_MAX = 9999
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ROWS*COLS*CW-1:0]   grid_in,
    output logic [ROWS*COLS*CW-1:0]   grid_out,
    output logic                      busy,
    output logic                      done,
    output logic [4:0]                lines_cleared,
    output logic [13:0]               score
);

    localparam int RW = COLS * CW;
    localparam int PW = $clog2(ROWS);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t          state;
    logic [RW-1:0]   wbuf [ROWS];
    logic [PW-1:0]   ptr;
    logic [4:0]      count;

    logic            row_full;
    logic [3:0]      pts;
    logic [14:0]     score_sum;
    logic [13:0]     score_next;

    // The row under the pointer is full when no cell holds the empty colour.
    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (wbuf[ptr][c*CW +: CW] == '0) row_full = 1'b0;
        end
    end

    always_comb begin
        case (count)
            5'd0:    pts = 4'd0;
            5'd1:    pts = 4'd1;
            5'd2:    pts = 4'd3;
            5'd3:    pts = 4'd5;
            default: pts = 4'd8;
        endcase
    end

    // One extra bit of headroom so that score + pts never wraps before it is clamped.
    always_comb begin
        score_sum  = {1'b0, score} + 15'(pts);
        score_next = (score_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : score_sum[13:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            for (int r = 0; r < ROWS; r++) wbuf[r] <= '0;
            grid_out      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines_cleared <= '0;
            score         <= '0;
            ptr           <= PW'(ROWS - 1);
            count         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start that coincides with the done pulse is dropped.
                    if (start && !done) begin
                        for (int r = 0; r < ROWS; r++) wbuf[r] <= grid_in[r*RW +: RW];
                        ptr   <= PW'(ROWS - 1);
                        count <= '0;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (row_full) begin
                        // Collapse everything above ptr down by one row. ptr does
                        // not move, so the row that dropped in is checked next cycle.
                        for (int k = ROWS - 1; k >= 1; k--) begin
                            if (k <= int'(ptr)) wbuf[k] <= wbuf[k-1];
                        end
                        wbuf[0] <= '0;
                        count   <= count + 5'd1;
                    end else if (ptr != '0) begin
                        ptr <= ptr - PW'(1);
                    end else begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    for (int r = 0; r < ROWS; r++) grid_out[r*RW +: RW] <= wbuf[r];
                    lines_cleared <= count;
                    score         <= score_next;
                    done          <= 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear_engine.sv
module tb_line_clear_engine;

    localparam int ROWS      = 22;
    localparam int COLS      = 10;
    localparam int CW        = 3;
    localparam int SCORE_MAX = 9999;
    localparam int RW        = COLS * CW;
    localparam int GW        = ROWS * COLS * CW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [GW-1:0] grid_in;
    logic [GW-1:0] grid_out;
    logic          busy;
    logic          done;
    logic [4:0]    lines_cleared;
    logic [13:0]   score;

    int checks = 0;
    int errors = 0;
    int model_score = 0;

    line_clear_engine #(.ROWS(ROWS), .COLS(COLS), .CW(CW), .SCORE_MAX(SCORE_MAX)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .grid_in       (grid_in),
        .grid_out      (grid_out),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .score         (score)
    );

    always #5 clk = ~clk;

    task automatic chk_g(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: keep the non-full rows in bottom-to-top order and stack them
    // at the bottom of an empty grid. The full rows are counted.
    function automatic void model(input logic [GW-1:0] g, output logic [GW-1:0] o, output int n);
        int w;
        logic [RW-1:0] row;
        bit full;
        o = '0;
        n = 0;
        w = ROWS - 1;
        for (int r = ROWS - 1; r >= 0; r--) begin
            row  = g[r*RW +: RW];
            full = 1'b1;
            for (int c = 0; c < COLS; c++) if (row[c*CW +: CW] == '0) full = 1'b0;
            if (full) n++;
            else begin
                o[w*RW +: RW] = row;
                w--;
            end
        end
    endfunction

    function automatic int points(input int n);
        int tab [5] = '{0, 1, 3, 5, 8};
        return tab[(n > 4) ? 4 : n];
    endfunction

    function automatic logic [GW-1:0] full_row(input logic [GW-1:0] g, input int r, input logic [CW-1:0] col);
        logic [GW-1:0] t = g;
        for (int c = 0; c < COLS; c++) t[(r*COLS+c)*CW +: CW] = col;
        return t;
    endfunction

    function automatic logic [GW-1:0] rand_grid();
        logic [GW-1:0] g = '0;
        int kind;
        for (int r = 0; r < ROWS; r++) begin
            kind = $urandom_range(0, 3);
            for (int c = 0; c < COLS; c++) begin
                if (kind == 0)      g[(r*COLS+c)*CW +: CW] = CW'($urandom_range(1, 7));
                else if (kind >= 2) g[(r*COLS+c)*CW +: CW] = CW'($urandom_range(0, 7));
            end
            if (kind >= 2) g[(r*COLS + $urandom_range(0, COLS-1))*CW +: CW] = '0;
        end
        return g;
    endfunction

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_score = 0;
    endtask

    // Runs one batch. scramble changes grid_in while busy (must be ignored);
    // poke raises start during the done cycle (must also be ignored).
    task automatic run_batch(input string tag, input logic [GW-1:0] g, input bit scramble, input bit poke);
        logic [GW-1:0] exp_g;
        int n, cyc;
        model(g, exp_g, n);
        model_score = model_score + points(n);
        if (model_score > SCORE_MAX) model_score = SCORE_MAX;
        grid_in = g;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk_n({tag, " busy_rise"}, int'(busy), 1);
        if (scramble) grid_in = rand_grid();
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!done && cyc < 100);
        chk_n({tag, " latency"}, cyc, ROWS + n + 1);
        chk_g({tag, " grid_out"}, grid_out, exp_g);
        chk_n({tag, " lines"}, int'(lines_cleared), n);
        chk_n({tag, " score"}, int'(score), model_score);
        chk_n({tag, " busy_at_done"}, int'(busy), 0);
        if (poke) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk_n({tag, " done_width"}, int'(done), 0);
        chk_n({tag, " no_restart"}, int'(busy), 0);
    endtask

    initial begin : stim
        logic [GW-1:0] g;
        int dones;

        rst = 1'b0;
        start = 1'b0;
        grid_in = '0;
        do_reset();
        chk_g("rst grid_out", grid_out, '0);
        chk_n("rst busy", int'(busy), 0);
        chk_n("rst done", int'(done), 0);
        chk_n("rst lines", int'(lines_cleared), 0);
        chk_n("rst score", int'(score), 0);

        // Empty grid.
        run_batch("t1", '0, 1'b0, 1'b0);

        // One full bottom row with a single block resting on it.
        g = full_row('0, 21, 3'b010);
        g[(20*COLS+4)*CW +: CW] = 3'b100;
        run_batch("t2", g, 1'b0, 1'b0);

        // Two full rows that are not adjacent.
        g = full_row('0, 21, 3'b011);
        g = full_row(g, 19, 3'b101);
        g[(20*COLS+0)*CW +: CW] = 3'b001;
        run_batch("t3", g, 1'b1, 1'b1);

        // Four full rows, run twice.
        g = '0;
        for (int r = 18; r < 22; r++) g = full_row(g, r, CW'(r % 7 + 1));
        run_batch("t4a", g, 1'b0, 1'b0);
        run_batch("t4b", g, 1'b0, 1'b1);

        // A full top row.
        g = full_row('0, 0, 3'b111);
        g[(21*COLS+2)*CW +: CW] = 3'b110;
        run_batch("t_row0", g, 1'b0, 1'b0);

        // Every row full.
        g = '0;
        for (int r = 0; r < ROWS; r++) g = full_row(g, r, 3'b001);
        run_batch("t_allfull", g, 1'b0, 1'b0);

        // Randomized batches.
        for (int i = 0; i < 20; i++) run_batch("rand", rand_grid(), 1'b1, i[0]);

        // Reset while scanning, with a repeated start that must be ignored.
        g = full_row('0, 21, 3'b010);
        grid_in = g;
        start = 1'b1;
        dones = 0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            start = (i == 5);
            @(posedge clk); #1;
            if (done) dones++;
        end
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_score = 0;
        chk_g("t5 grid_out", grid_out, '0);
        chk_n("t5 busy", int'(busy), 0);
        chk_n("t5 lines", int'(lines_cleared), 0);
        chk_n("t5 score", int'(score), 0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk_n("t5 no_done", dones, 0);
        run_batch("t5 after", g, 1'b0, 1'b0);

        // Saturation: 9992 via four-line batches, +3 to 9995, +8 clamps, +1 holds.
        do_reset();
        g = '0;
        for (int r = 18; r < 22; r++) g = full_row(g, r, 3'b100);
        for (int i = 0; i < 1249; i++) run_batch("sat pre", g, 1'b0, 1'b0);
        chk_n("sat 9992", int'(score), 9992);
        run_batch("sat two", full_row(full_row('0, 21, 3'b001), 20, 3'b001), 1'b0, 1'b0);
        chk_n("sat 9995", int'(score), 9995);
        run_batch("sat four", g, 1'b0, 1'b0);
        chk_n("sat clamp", int'(score), 9999);
        run_batch("sat one", full_row('0, 21, 3'b001), 1'b0, 1'b0);
        chk_n("sat hold", int'(score), 9999);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
